uart_autobaud: RTL
==================

// Module: uart_autobaud
// PURPOSE
//  Automatic baud-rate detector feeding the clk_div input of uart_rx.
//  Watches the raw rx pin for the sync character 0x55 ('U'), measures the span of
//  8 bit times (1st to 5th falling edge) and outputs the rounded clocks-per-bit.
//  Sits between the pmod rx pin and uart_rx; host enables it via a setup register bit.
// PARAMETERS
//  CNT_WIDTH    16  width of clk_div output (matches uart_rx clk_div)
//  MIN_BIT_CLKS 4   shortest legal edge-to-edge segment, in clk cycles (glitch reject)
//  IDLE_CLKS    64  consecutive high cycles required before arming
//  DEFAULT_DIV  868 clk_div value after reset (115200 baud at 100 MHz)
// PORTS
//  clk     in  1          system clock
//  rst_n   in  1          asynchronous reset, active-low
//  en      in  1          level; high = run detection, low = return to IDLE
//  rx      in  1          raw asynchronous serial line (idle high)
//  clk_div out CNT_WIDTH  measured clocks per bit (last successful result)
//  locked  out 1          high while clk_div holds a result from the current enable
//  done    out 1          one-cycle pulse when clk_div is updated
//  error   out 1          one-cycle pulse on failed measurement
//  busy    out 1          high in WAIT_START edge-armed MEASURE state
// BEHAVIOUR
//  Reset: clk_div=DEFAULT_DIV, locked=0, done=0, error=0, busy=0, state=IDLE.
//  rx passes a 2-flop synchronizer; edges detected on synced value (3-cycle latency).
//  States: IDLE -> WAIT_IDLE -> WAIT_START -> MEASURE -> DONE -> WAIT_IDLE; ERROR -> WAIT_IDLE.
//  IDLE: en=0. en rising -> WAIT_IDLE, clears locked.
//  WAIT_IDLE: idle counter counts synced-high cycles, clears on low; at IDLE_CLKS -> WAIT_START.
//  WAIT_START: first falling edge -> MEASURE; span counter (CNT_WIDTH+3 bits) and
//   segment counter cleared, falling-edge counter =0.
//  MEASURE: span and segment counters increment every cycle. On every edge (either
//   polarity): if segment < MIN_BIT_CLKS -> ERROR; else segment cleared.
//   On 4th further falling edge (5th total) -> DONE with span = 8 bit times.
//   Span counter reaching all-ones -> ERROR (line too slow / not 0x55).
//  DONE (1 cycle): clk_div <= (span + 4) >> 3 (round-to-nearest, truncated to
//   CNT_WIDTH); if result < MIN_BIT_CLKS -> ERROR instead. done=1, locked=1.
//  ERROR (1 cycle): error=1; clk_div, locked unchanged; then WAIT_IDLE (auto-retry).
//  en low in any state -> IDLE next cycle; clk_div retained; locked retained.
//  Edge on same cycle as span saturation: saturation wins (ERROR).
//  rst_n asserted mid-measure: immediate return to reset values.
//  After DONE the block re-arms (WAIT_IDLE) and overwrites clk_div on each valid 0x55.
// STRUCTURE
//  Shared include uart_defs.vh: state encodings, SYNC_CHAR=8'h55, SPAN_BITS=3 shift.
//  One sub-module: bit_synchronizer (2-flop, async active-low reset to 1).
//  Top-level wiring: en from rx setup reg bit 13, clk_div mux into uart_rx.
// TESTING (clk 100 MHz)
//  0x55 at 115200 (868 clks/bit), en=1 -> done pulse, clk_div=868, locked=1.
//  0x55 at 9600 (10417 clks/bit) with +/-3 clk edge jitter -> clk_div=10417.
//  2-cycle low glitch on idle line after arming -> error pulse, clk_div unchanged, re-arms.
//  0x00 sent (single falling edge) -> span saturates at 524287 -> error pulse.
//  en dropped after 2nd falling edge -> IDLE, busy=0, clk_div keeps prior value.
//  rst_n low mid-MEASURE -> clk_div=868, all flags 0; after release 0x55 @57600 -> 1736.

Source files
------------

// File: rtl/uart_autobaud_pkg.sv
// Shared types and constants for the uart_autobaud detector.
// Holds the FSM encoding and the sync-character constants.
package uart_autobaud_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_IDLE,
    S_WAIT_START,
    S_MEASURE,
    S_DONE,
    S_ERROR
  } ab_state_e;

  localparam logic [7:0] SYNC_CHAR = 8'h55;
  localparam int SPAN_BITS = 3;
  localparam int SYNC_FALLS = 5;

endpackage

// File: rtl/uart_autobaud_sync.sv
// Two-flop synchronizer for the raw rx pin.
// Resets to the idle-high line level.
module uart_autobaud_sync
  import uart_autobaud_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_q <= 2'b11;
    end else begin
      ff_q <= {ff_q[0], d_i};
    end
  end

  assign q_o = ff_q[1];

endmodule

// File: rtl/uart_autobaud.sv
// Baud-rate detector: times 8 bit periods of a 0x55 sync char
// (1st to 5th falling edge) and reports rounded clocks per bit.
module uart_autobaud
  import uart_autobaud_pkg::*;
#(
  parameter int          CNT_WIDTH    = 16,
  parameter int          MIN_BIT_CLKS = 4,
  parameter int          IDLE_CLKS    = 64,
  parameter int unsigned DEFAULT_DIV  = 868
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 rx,
  output logic [CNT_WIDTH-1:0] clk_div,
  output logic                 locked,
  output logic                 done,
  output logic                 error,
  output logic                 busy
);

  localparam int SW = CNT_WIDTH + SPAN_BITS;
  localparam int IW = $clog2(IDLE_CLKS + 1);

  ab_state_e            state_q;
  logic [CNT_WIDTH-1:0] div_q;
  logic                 locked_q;
  logic                 done_q;
  logic                 err_q;
  logic                 busy_q;
  logic [IW-1:0]        idle_q;
  logic [SW-1:0]        span_q;
  logic [SW-1:0]        seg_q;
  logic [1:0]           fall_q;
  logic                 rx_p_q;

  logic                 rx_s;
  logic                 fall;
  logic                 rise;
  logic [SW-1:0]        rnd;
  logic [CNT_WIDTH-1:0] rdiv;
  logic                 rdiv_low;
  logic                 seg_low;
  logic                 span_sat;

  uart_autobaud_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  assign fall     = rx_p_q & ~rx_s;
  assign rise     = ~rx_p_q & rx_s;
  assign rnd      = span_q + SW'(4);
  assign rdiv     = CNT_WIDTH'(rnd >> SPAN_BITS);
  assign rdiv_low = rdiv < CNT_WIDTH'(MIN_BIT_CLKS);
  assign seg_low  = seg_q < SW'(MIN_BIT_CLKS);
  assign span_sat = &span_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      div_q    <= CNT_WIDTH'(DEFAULT_DIV);
      locked_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      idle_q   <= '0;
      span_q   <= '0;
      seg_q    <= '0;
      fall_q   <= '0;
      rx_p_q   <= 1'b1;
    end else begin
      rx_p_q <= rx_s;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (!en) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            state_q  <= S_WAIT_IDLE;
            locked_q <= 1'b0;
            idle_q   <= '0;
          end
          S_WAIT_IDLE: begin
            if (!rx_s) begin
              idle_q <= '0;
            end else if (idle_q == IW'(IDLE_CLKS - 1)) begin
              state_q <= S_WAIT_START;
              busy_q  <= 1'b1;
            end else begin
              idle_q <= idle_q + 1'b1;
            end
          end
          S_WAIT_START: begin
            if (fall) begin
              state_q <= S_MEASURE;
              span_q  <= SW'(1);
              seg_q   <= SW'(1);
              fall_q  <= '0;
            end
          end
          S_MEASURE: begin
            span_q <= span_q + 1'b1;
            seg_q  <= seg_q + 1'b1;
            // saturation outranks any edge seen in the same cycle
            if (span_sat) begin
              state_q <= S_ERROR;
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
            end else if (fall || rise) begin
              if (seg_low) begin
                state_q <= S_ERROR;
                err_q   <= 1'b1;
                busy_q  <= 1'b0;
              end else begin
                seg_q <= SW'(1);
                if (fall && fall_q == 2'd3) begin
                  busy_q <= 1'b0;
                  if (rdiv_low) begin
                    state_q <= S_ERROR;
                    err_q   <= 1'b1;
                  end else begin
                    state_q  <= S_DONE;
                    div_q    <= rdiv;
                    done_q   <= 1'b1;
                    locked_q <= 1'b1;
                  end
                end else if (fall) begin
                  fall_q <= fall_q + 1'b1;
                end
              end
            end
          end
          S_DONE, S_ERROR: begin
            state_q <= S_WAIT_IDLE;
            idle_q  <= '0;
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign clk_div = div_q;
  assign locked  = locked_q;
  assign done    = done_q;
  assign error   = err_q;
  assign busy    = busy_q;

endmodule
